// File: rtl/slave_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// slave_ctrl_pkg : shared state encoding and link/timer constants
// Rev 1.0
// ---------------------------------------------------------------------------
package slave_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NOTICE = 2'd1,
    ACK    = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DATA_W_DEFAULT = 4;
  localparam int ONE_SEC_CYCLES = 100_000_000;

endpackage
`default_nettype wire

// File: rtl/slave_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// slave_ctrl_if : inter-board handshake pins (request/valid/data/ack)
// Rev 1.0
// ---------------------------------------------------------------------------
interface slave_ctrl_if #(
  parameter int DATA_W = slave_ctrl_pkg::DATA_W_DEFAULT
);
  logic              request;
  logic              valid;
  logic [DATA_W-1:0] data_in;
  logic              ack;

  modport master (output request, output valid, output data_in, input ack);
  modport slave  (input request, input valid, input data_in, output ack);
endinterface
`default_nettype wire

// File: rtl/slave_ctrl_sync_ff.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_ff : SYNC_STAGES-deep single-bit synchroniser, sync active-low reset
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/slave_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// slave_ctrl : slave-side link handshake - notice window, ack, data latch
// Rev 1.0
// ---------------------------------------------------------------------------
module slave_ctrl
  import slave_ctrl_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  wire               clk,
  input  wire               rst_n,
  slave_ctrl_if.slave       lnk,
  output logic              notice,
  output logic              timer_start,
  input  wire               timer_done,
  output logic [DATA_W-1:0] data_out
);

  logic req_s;
  logic val_s;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lnk.request),
    .q     (req_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_val (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lnk.valid),
    .q     (val_s)
  );

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic              notice_q, notice_d;
  logic              timer_start_q, timer_start_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_s) state_d = NOTICE;
      end
      NOTICE: begin
        // A dropped request beats a coincident timer_done.
        if (!req_s)          state_d = IDLE;
        else if (timer_done) state_d = ACK;
      end
      ACK: begin
        if (val_s) begin
          data_d  = lnk.data_in;
          state_d = HOLD;
        end else if (!req_s) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (!val_s && !req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies decoded from the next state.
    ack_d         = (state_d == ACK) || (state_d == HOLD);
    notice_d      = (state_d == NOTICE);
    timer_start_d = (state_d == NOTICE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ack_q         <= 1'b0;
      notice_q      <= 1'b0;
      timer_start_q <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      notice_q      <= notice_d;
      timer_start_q <= timer_start_d;
      data_q        <= data_d;
    end
  end

  assign lnk.ack     = ack_q;
  assign notice      = notice_q;
  assign timer_start = timer_start_q;
  assign data_out    = data_q;

endmodule
`default_nettype wire
